// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-master memory arbiter: state encoding, master
// indices, the default access latency and the per-master request bundle.
package mem_arb_pkg;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StResp   = 2'd2;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int unsigned DefaultMemLatency = 1;
  localparam int unsigned CntW              = 4;

  typedef struct packed {
    logic        write;
    logic        lock;
    logic [31:0] addr;
    logic [31:0] wdata;
  } xfer_req_t;

  // The counter counts down to zero, so a latency of L loads L-1.
  function automatic logic [CntW-1:0] cnt_preload(input int unsigned lat);
    return CntW'(lat - 1);
  endfunction

endpackage

// File: rtl/arb_rr_select.sv
// Combinational grant selection: lock eligibility filter followed by a
// two-way round robin that favours the master not granted last.
module arb_rr_select
  import mem_arb_pkg::*;
(
  input  logic [1:0] reqs,
  input  logic       last_grant,
  input  logic       locked,
  input  logic       owner,
  output logic       grant_valid,
  output logic       grant_idx
);

  logic [1:0] eligible;

  always_comb begin
    eligible = reqs;
    if (locked) begin
      eligible = (owner == M1) ? (reqs & 2'b10) : (reqs & 2'b01);
    end

    grant_valid = |eligible;
    case (eligible)
      2'b01:   grant_idx = M0;
      2'b10:   grant_idx = M1;
      default: grant_idx = ~last_grant;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a fixed-latency memory controller.
// One transfer at a time: IDLE (arbitrate) -> ACCESS (MEM_LATENCY cycles) -> RESP (ack).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = DefaultMemLatency
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_lock,
  input  logic        m0_write,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m1_req,
  input  logic        m1_lock,
  input  logic        m1_write,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m0_ack,
  output logic        m1_ack,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_trans,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            write_q, write_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            locked_q, locked_d;
  logic            owner_q, owner_d;
  logic            last_grant_q, last_grant_d;
  logic            winner_q, winner_d;

  xfer_req_t m0_bus, m1_bus, sel_bus;
  logic      owner_lock, eff_locked;
  logic      grant_valid, grant_idx;

  always_comb begin
    m0_bus = '{write: m0_write, lock: m0_lock, addr: m0_addr, wdata: m0_wdata};
    m1_bus = '{write: m1_write, lock: m1_lock, addr: m1_addr, wdata: m1_wdata};
    // The lock is released as soon as its owner drops lock in an IDLE cycle,
    // and that same cycle arbitrates as if unlocked.
    owner_lock = (owner_q == M1) ? m1_lock : m0_lock;
    eff_locked = locked_q & owner_lock;
  end

  arb_rr_select u_select (
    .reqs        ({m1_req, m0_req}),
    .last_grant  (last_grant_q),
    .locked      (eff_locked),
    .owner       (owner_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign sel_bus = (grant_idx == M1) ? m1_bus : m0_bus;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    rdata_d      = rdata_q;
    locked_d     = locked_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    winner_d     = winner_q;

    case (state_q)
      StIdle: begin
        locked_d = eff_locked;
        if (grant_valid) begin
          state_d      = StAccess;
          cnt_d        = cnt_preload(MEM_LATENCY);
          addr_d       = sel_bus.addr;
          wdata_d      = sel_bus.wdata;
          write_d      = sel_bus.write;
          winner_d     = grant_idx;
          last_grant_d = grant_idx;
          locked_d     = sel_bus.lock;
          owner_d      = sel_bus.lock ? grant_idx : owner_q;
        end
      end
      StAccess: begin
        if (cnt_q == '0) begin
          state_d = StResp;
          write_d = 1'b0;
          if (!write_q) begin
            rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      rdata_q      <= '0;
      locked_q     <= 1'b0;
      owner_q      <= M0;
      last_grant_q <= M1;
      winner_q     <= M0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
      rdata_q      <= rdata_d;
      locked_q     <= locked_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      winner_q     <= winner_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_write = write_q;
  assign rdata     = rdata_q;
  assign mem_trans = (state_q == StAccess);
  assign busy      = (state_q != StIdle);
  assign m0_ack    = (state_q == StResp) && (winner_q == M0);
  assign m1_ack    = (state_q == StResp) && (winner_q == M1);

endmodule
